rgf_wb_arb: RTL
===============

Name: rgf_wb_arb

Overview:
- Write-port arbiter and sequencer for the 32x32 register file, which has a single write port written on the falling clock edge.
- Arbitrates between two writeback sources: the ALU pipe and the load/store unit (LSU). Each source uses a valid/ready handshake.
- Drives the register-file write port from registered outputs, so write enable, address and data are stable across the falling edge.
- Uses fixed LSU priority with a starvation guard for the ALU, and keeps a saturating count of contested cycles for performance debug.

Parameters:
- XLEN, 32, data width of the write port.
- MAX_STALL, 3, maximum number of consecutive contested cycles the ALU may lose before it is forced a grant (must be at least 1).
- STAT_W, 16, width of the contention statistics counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- alu_valid  in  1  ALU has a result to write back.
- alu_rd  in  5  ALU destination register.
- alu_data  in  XLEN  ALU result.
- alu_ready  out  1  ALU request accepted this cycle.
- lsu_valid  in  1  LSU has load data to write back.
- lsu_rd  in  5  LSU destination register.
- lsu_data  in  XLEN  load data.
- lsu_ready  out  1  LSU request accepted this cycle.
- rf_we  out  1  register-file write enable (registered).
- rf_wn  out  5  register-file write register (registered).
- rf_data  out  XLEN  register-file write data (registered).
- conflict_cnt  out  STAT_W  saturating count of contested cycles.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- While rst=1: alu_ready=0, lsu_ready=0. At the rising edge with rst=1: rf_we<=0, rf_wn<=0, rf_data<=0, starve_cnt<=0, conflict_cnt<=0.
- Reset mid-operation: any request not yet accepted is dropped, and a pending rf_we is cleared at that edge.
- Handshake:
  - A transfer occurs at a rising edge where valid && ready.
  - Sources hold rd and data stable while valid=1 and ready=0.
  - ready is combinational from valid and arbiter state; it never depends on next-cycle state.
  - At most one ready is high per cycle.
- Grant rules, evaluated each cycle with rst=0:
  - Only lsu_valid: grant LSU.
  - Only alu_valid: grant ALU.
  - Both valid and starve_cnt < MAX_STALL: grant LSU; starve_cnt increments.
  - Both valid and starve_cnt == MAX_STALL: grant ALU; starve_cnt<=0.
  - Any ALU grant, or alu_valid=0: starve_cnt<=0.
  - Neither valid: no grant.
- Write-port register, 1-cycle latency:
  - A transfer at edge N sets rf_we=1, rf_wn=rd and rf_data=data for the cycle after edge N. The register file captures them on the falling edge within that cycle.
  - With no transfer: rf_we<=0, and rf_wn/rf_data hold their previous values.
- rd==0:
  - The request is accepted normally (ready asserted, grant and starve logic unchanged).
  - rf_we<=0 for it, so x0 is never written.
- Same rd from both sources in a contested cycle: writes occur in grant order, one per cycle. The later grant overwrites the earlier; there is no merging.
- conflict_cnt:
  - Increments by 1 at every edge where alu_valid && lsu_valid, independent of the grant outcome.
  - Saturates at 2^STAT_W-1.
- Back-to-back transfers are allowed every cycle, giving full throughput of one write per cycle.
- No combinational path from the inputs to rf_we, rf_wn or rf_data.

Test Plan:
- Reset: hold rst=1 for 2 cycles with both valids high. Required: both readies 0 during reset; rf_we=0, rf_wn=0, rf_data=0, conflict_cnt=0 after the reset edge.
- Single source: alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF for one cycle. Required: alu_ready=1 that cycle; next cycle rf_we=1, rf_wn=5, rf_data=0xDEADBEEF; the cycle after, rf_we=0.
- Starvation guard (MAX_STALL=3): both valid continuously with LSU rd=1..6 and ALU rd=9 held. Required grant sequence: L,L,L,A,L,L,L,A; conflict_cnt=8 after 8 cycles.
- x0 write: lsu_valid=1, lsu_rd=0, lsu_data=0x12345678. Required: lsu_ready=1; next cycle rf_we=0.
- Same-rd collision: both valid with rd=7, alu_data=0xA, lsu_data=0xB, starve_cnt=0. Required: LSU write 0xB first, then ALU write 0xA; final x7=0xA.
- Reset mid-stream plus saturation:
  - Assert rst during a contested stream. Required: rf_we=0 next cycle, starve_cnt restarts, and the next contested cycles grant LSU first.
  - Run with STAT_W=4 and 20 contested cycles. Required: conflict_cnt=15.

Source files
------------

// File: rtl/rgf_wb_arb.sv
// Register-file write-port arbiter.
// Two writeback sources (ALU, LSU) compete for the single register-file write
// port. The LSU wins by default; the ALU is forced a grant after losing
// MAX_STALL consecutive contested cycles. The winning request is registered
// onto the write port so rf_we/rf_wn/rf_data are stable across the falling
// edge on which the register file captures them.
//
// Handshake: a transfer happens at a rising edge where valid && ready. A
// source holds rd/data stable while valid=1 and ready=0. ready is a purely
// combinational function of valid and current arbiter state, and at most
// one ready is high per cycle.
module rgf_wb_arb #(
  parameter int XLEN      = 32,
  parameter int MAX_STALL = 3,
  parameter int STAT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [4:0]        alu_rd,
  input  logic [XLEN-1:0]   alu_data,
  output logic              alu_ready,
  input  logic              lsu_valid,
  input  logic [4:0]        lsu_rd,
  input  logic [XLEN-1:0]   lsu_data,
  output logic              lsu_ready,
  output logic              rf_we,
  output logic [4:0]        rf_wn,
  output logic [XLEN-1:0]   rf_data,
  output logic [STAT_W-1:0] conflict_cnt
);

  localparam int SW = (MAX_STALL < 1) ? 1 : $clog2(MAX_STALL + 1);
  localparam logic [SW-1:0] STALL_MAX = SW'(MAX_STALL);

  logic [SW-1:0] starve_cnt;
  logic          contested;
  logic          force_alu;
  logic          xfer;
  logic [4:0]    win_rd;
  logic [XLEN-1:0] win_data;

  assign contested = alu_valid && lsu_valid;
  assign force_alu = (starve_cnt == STALL_MAX);

  // Grant decision: LSU priority, ALU forced once its stall budget is spent.
  always_comb begin
    alu_ready = 1'b0;
    lsu_ready = 1'b0;
    if (!rst) begin
      if (contested) begin
        alu_ready = force_alu;
        lsu_ready = !force_alu;
      end else begin
        alu_ready = alu_valid;
        lsu_ready = lsu_valid;
      end
    end
  end

  assign xfer     = alu_ready || lsu_ready;
  assign win_rd   = alu_ready ? alu_rd : lsu_rd;
  assign win_data = alu_ready ? alu_data : lsu_data;

  // Starvation counter: counts consecutive contested cycles the ALU lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (contested && lsu_ready) begin
      starve_cnt <= starve_cnt + 1'b1;
    end else begin
      starve_cnt <= '0;
    end
  end

  // Write-port register; an accepted write to x0 is swallowed (rf_we=0).
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we   <= 1'b0;
      rf_wn   <= '0;
      rf_data <= '0;
    end else if (xfer) begin
      rf_we   <= (win_rd != 5'd0);
      rf_wn   <= win_rd;
      rf_data <= win_data;
    end else begin
      rf_we   <= 1'b0;
    end
  end

  // Saturating count of cycles where both sources requested.
  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_cnt <= '0;
    end else if (contested && (conflict_cnt != {STAT_W{1'b1}})) begin
      conflict_cnt <= conflict_cnt + 1'b1;
    end
  end

endmodule
